// File: rtl/vga_timing_pkg.sv
// Shared timing constants, counter width and phase type for the VGA raster generator.
// Defaults describe the 640x480@60 mode driven from a 25 MHz pixel clock.
package vga_timing_pkg;

   localparam int CNT_W     = 10;
   localparam int MAX_TOTAL = 1 << CNT_W;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int H_TOTAL_D      = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int V_TOTAL_D      = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
   localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
   localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D - 1;
   localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
   localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D - 1;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_t;

   // Phase of a position along one axis: ACTIVE, then front porch, sync, back porch.
   function automatic phase_t phase_of(input int pos, input int active, input int fp,
                                       input int sync);
      phase_t ph;
      if (pos < active) begin
         ph = PH_ACTIVE;
      end else if (pos < active + fp) begin
         ph = PH_FP;
      end else if (pos < active + fp + sync) begin
         ph = PH_SYNC;
      end else begin
         ph = PH_BP;
      end
      return ph;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with registered phase and sync level.
// All registered outputs are decoded from the position being loaded, so they stay coherent with count.
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE   = H_ACTIVE_D,
   parameter int FP       = H_FP_D,
   parameter int SYNC     = H_SYNC_D,
   parameter int BP       = H_BP_D,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_step,
   output logic [CNT_W-1:0] count,
   output phase_t           phase,
   output logic             wrap,
   output logic             sync,
   output logic             active
);

   localparam int               TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] nxt;
   phase_t           nxt_phase;

   // wrap and active describe the step about to happen, letting the parent register its own decode.
   always_comb begin
      wrap = i_step && (count == LAST);
      nxt  = count;
      if (wrap) begin
         nxt = '0;
      end else if (i_step) begin
         nxt = count + 1'b1;
      end
      nxt_phase = phase_of(int'(nxt), ACTIVE, FP, SYNC);
      active    = (nxt_phase == PH_ACTIVE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= LAST;
         phase <= PH_BP;
         sync  <= ~SYNC_POL;
      end else begin
         count <= nxt;
         phase <= nxt_phase;
         sync  <= (nxt_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: sync pulses, pixel coordinate, visible flag, line/frame strobes
// and an 8-bit frame counter, all registered and describing the same (o_hcnt, o_vcnt) position.
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic [CNT_W-1:0] o_hcnt,
   output logic [CNT_W-1:0] o_vcnt,
   output logic             o_active,
   output logic             o_line_start,
   output logic             o_frame_start,
   output logic [7:0]       o_frame,
   output phase_t           o_hphase,
   output phase_t           o_vphase
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
      $error("vga_timing: H_TOTAL/V_TOTAL exceed the counter range");
   end

   logic h_wrap;
   logic v_wrap;
   logic h_act;
   logic v_act;
   logic v_step;

   assign v_step = h_wrap & i_en;

   vga_axis_cnt #(
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_step  (i_en),
      .count   (o_hcnt),
      .phase   (o_hphase),
      .wrap    (h_wrap),
      .sync    (o_hsync),
      .active  (h_act)
   );

   // The vertical axis only steps on a line boundary, so vsync can never change mid-line.
   vga_axis_cnt #(
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_step  (v_step),
      .count   (o_vcnt),
      .phase   (o_vphase),
      .wrap    (v_wrap),
      .sync    (o_vsync),
      .active  (v_act)
   );

   // Strobes hold while i_en is low so a pulse spans exactly one enabled period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_active      <= 1'b0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame       <= 8'hFF;
      end else if (i_en) begin
         o_active      <= h_act & v_act;
         o_line_start  <= h_wrap;
         o_frame_start <= h_wrap & v_wrap;
         if (h_wrap && v_wrap) begin
            o_frame <= o_frame + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for line/enable/reset checks, scaled instance for frame-level checks.
`timescale 1ns/1ps
module tb_vga_timing;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, rst_b, en_b;
   logic       a_hs, a_vs, a_act, a_ls, a_fs;
   logic [9:0] a_h, a_v;
   logic [7:0] a_frame;
   phase_t     a_hph, a_vph;
   logic       b_hs, b_vs, b_act, b_ls, b_fs;
   logic [9:0] b_h, b_v;
   logic [7:0] b_frame;
   phase_t     b_hph, b_vph;

   int vec_cnt = 0;
   int err_cnt = 0;

   vga_timing u_dut_a (
      .i_clk (clk), .i_rst_n (rst_a), .i_en (en_a),
      .o_hsync (a_hs), .o_vsync (a_vs), .o_hcnt (a_h), .o_vcnt (a_v),
      .o_active (a_act), .o_line_start (a_ls), .o_frame_start (a_fs),
      .o_frame (a_frame), .o_hphase (a_hph), .o_vphase (a_vph)
   );

   // Scaled timing: H 8/2/4/2 (total 16, hsync 10..13), V 6/1/2/1 (total 10, vsync rows 7..8).
   vga_timing #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (4), .H_BP (2),
      .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
   ) u_dut_b (
      .i_clk (clk), .i_rst_n (rst_b), .i_en (en_b),
      .o_hsync (b_hs), .o_vsync (b_vs), .o_hcnt (b_h), .o_vcnt (b_v),
      .o_active (b_act), .o_line_start (b_ls), .o_frame_start (b_fs),
      .o_frame (b_frame), .o_hphase (b_hph), .o_vphase (b_vph)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_a = 1'b0; en_a = 1'b0; rst_b = 1'b0; en_b = 1'b0;
      repeat (2) tick();
      vec_cnt++;
      if (a_h !== 10'd799 || a_v !== 10'd524) begin
         err_cnt++;
         $display("FAIL reset_pos: got (%0d,%0d) want (799,524)", a_h, a_v);
      end
      vec_cnt++;
      if ({a_hs, a_vs, a_act, a_ls, a_fs} !== 5'b11000) begin
         err_cnt++;
         $display("FAIL reset_flags: got %b want 11000", {a_hs, a_vs, a_act, a_ls, a_fs});
      end
      vec_cnt++;
      if (a_frame !== 8'hFF || a_hph !== PH_BP || a_vph !== PH_BP) begin
         err_cnt++;
         $display("FAIL reset_frame: got frame=%h hph=%0d vph=%0d want FF 3 3", a_frame, a_hph, a_vph);
      end
      rst_a = 1'b1; en_a = 1'b1;
      tick();
      vec_cnt++;
      if (a_h !== 10'd0 || a_v !== 10'd0) begin
         err_cnt++;
         $display("FAIL first_pos: got (%0d,%0d) want (0,0)", a_h, a_v);
      end
      vec_cnt++;
      if ({a_hs, a_vs, a_act, a_ls, a_fs} !== 5'b11111 || a_frame !== 8'h00) begin
         err_cnt++;
         $display("FAIL first_flags: got %b frame=%h want 11111 frame=00",
                  {a_hs, a_vs, a_act, a_ls, a_fs}, a_frame);
      end
   endtask

   task automatic test_line;
      int hs_low = 0, hs_first = -1, hs_last = -1, act_fall = -1, ls_cnt = 0;
      for (int k = 1; k <= 800; k++) begin
         tick();
         vec_cnt++;
         if (a_h !== 10'(k % 800) || a_v !== 10'(k / 800)) begin
            err_cnt++;
            $display("FAIL line_pos k=%0d: got (%0d,%0d) want (%0d,%0d)", k, a_h, a_v, k % 800, k / 800);
         end
         if (!a_hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = int'(a_h);
            hs_last = int'(a_h);
         end
         if (!a_act && act_fall < 0) act_fall = int'(a_h);
         if (a_ls) ls_cnt++;
      end
      vec_cnt++;
      if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
         err_cnt++;
         $display("FAIL hsync_window: got %0d cycles %0d..%0d want 96 cycles 656..751", hs_low, hs_first, hs_last);
      end
      vec_cnt++;
      if (act_fall != 640) begin
         err_cnt++;
         $display("FAIL active_fall: got %0d want 640", act_fall);
      end
      vec_cnt++;
      if (ls_cnt != 1 || a_ls !== 1'b1 || a_fs !== 1'b0 || a_act !== 1'b1) begin
         err_cnt++;
         $display("FAIL line_strobe: got cnt=%0d ls=%b fs=%b act=%b want 1 1 0 1", ls_cnt, a_ls, a_fs, a_act);
      end
   endtask

   task automatic test_enable_freeze;
      repeat (700) tick();
      vec_cnt++;
      if (a_h !== 10'd700 || a_v !== 10'd1) begin
         err_cnt++;
         $display("FAIL freeze_entry: got (%0d,%0d) want (700,1)", a_h, a_v);
      end
      en_a = 1'b0;
      for (int k = 0; k < 37; k++) begin
         tick();
         vec_cnt++;
         if (a_h !== 10'd700 || a_v !== 10'd1 || {a_hs, a_vs, a_act, a_ls, a_fs} !== 5'b01000) begin
            err_cnt++;
            $display("FAIL freeze_hold k=%0d: got (%0d,%0d) flags=%b want (700,1) 01000",
                     k, a_h, a_v, {a_hs, a_vs, a_act, a_ls, a_fs});
         end
      end
      en_a = 1'b1;
      tick();
      vec_cnt++;
      if (a_h !== 10'd701 || a_v !== 10'd1) begin
         err_cnt++;
         $display("FAIL freeze_resume: got (%0d,%0d) want (701,1)", a_h, a_v);
      end
      repeat (99) tick();
      vec_cnt++;
      if (a_h !== 10'd0 || a_v !== 10'd2 || a_ls !== 1'b1) begin
         err_cnt++;
         $display("FAIL freeze_next_line: got (%0d,%0d) ls=%b want (0,2) 1", a_h, a_v, a_ls);
      end
   endtask

   task automatic test_async_reset;
      repeat (300) tick();
      vec_cnt++;
      if (a_h !== 10'd300 || a_v !== 10'd2 || a_act !== 1'b1) begin
         err_cnt++;
         $display("FAIL pre_reset: got (%0d,%0d) act=%b want (300,2) 1", a_h, a_v, a_act);
      end
      #2 rst_a = 1'b0;
      #1;
      vec_cnt++;
      if (a_h !== 10'd799 || a_v !== 10'd524 || {a_hs, a_vs, a_act, a_ls, a_fs} !== 5'b11000
          || a_frame !== 8'hFF) begin
         err_cnt++;
         $display("FAIL async_reset: got (%0d,%0d) flags=%b frame=%h want (799,524) 11000 FF",
                  a_h, a_v, {a_hs, a_vs, a_act, a_ls, a_fs}, a_frame);
      end
      repeat (3) tick();
      vec_cnt++;
      if (a_h !== 10'd799 || a_v !== 10'd524 || a_fs !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_hold: got (%0d,%0d) fs=%b want (799,524) 0", a_h, a_v, a_fs);
      end
      rst_a = 1'b1;
      tick();
      vec_cnt++;
      if (a_h !== 10'd0 || a_v !== 10'd0 || a_fs !== 1'b1 || a_frame !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_release: got (%0d,%0d) fs=%b frame=%h want (0,0) 1 00", a_h, a_v, a_fs, a_frame);
      end
   endtask

   task automatic test_small_frame;
      int vs_low = 0, fs_cnt = 0;
      rst_b = 1'b1; en_b = 1'b1;
      tick();
      vec_cnt++;
      if (b_h !== 10'd0 || b_v !== 10'd0 || b_fs !== 1'b1 || b_frame !== 8'h00) begin
         err_cnt++;
         $display("FAIL small_first: got (%0d,%0d) fs=%b frame=%h want (0,0) 1 00", b_h, b_v, b_fs, b_frame);
      end
      for (int k = 1; k <= 160; k++) begin
         int     eh, ev;
         logic   e_hs, e_vs, e_act, e_ls, e_fs;
         phase_t e_hph;
         tick();
         eh    = k % 16;
         ev    = (k / 16) % 10;
         e_hs  = !(eh >= 10 && eh <= 13);
         e_vs  = !(ev >= 7 && ev <= 8);
         e_act = (eh < 8) && (ev < 6);
         e_ls  = (eh == 0);
         e_fs  = (eh == 0) && (ev == 0);
         e_hph = (eh < 8) ? PH_ACTIVE : (eh < 10) ? PH_FP : (eh < 14) ? PH_SYNC : PH_BP;
         vec_cnt++;
         if (b_h !== 10'(eh) || b_v !== 10'(ev) || b_hph !== e_hph
             || {b_hs, b_vs, b_act, b_ls, b_fs} !== {e_hs, e_vs, e_act, e_ls, e_fs}) begin
            err_cnt++;
            $display("FAIL small_raster k=%0d: got (%0d,%0d) ph=%0d flags=%b want (%0d,%0d) ph=%0d flags=%b",
                     k, b_h, b_v, b_hph, {b_hs, b_vs, b_act, b_ls, b_fs}, eh, ev, e_hph,
                     {e_hs, e_vs, e_act, e_ls, e_fs});
         end
         if (!b_vs) vs_low++;
         if (b_fs) fs_cnt++;
      end
      vec_cnt++;
      if (vs_low != 32 || fs_cnt != 1 || b_frame !== 8'h01) begin
         err_cnt++;
         $display("FAIL small_frame: got vs_low=%0d fs=%0d frame=%h want 32 1 01", vs_low, fs_cnt, b_frame);
      end
   endtask

   task automatic test_frame_wrap;
      for (int f = 2; f <= 256; f++) begin
         repeat (160) tick();
         vec_cnt++;
         if (b_fs !== 1'b1 || b_frame !== 8'(f)) begin
            err_cnt++;
            $display("FAIL frame_count f=%0d: got fs=%b frame=%h want 1 %h", f, b_fs, b_frame, 8'(f));
         end
      end
   endtask

   task automatic test_stretch;
      int n = 0;
      bit frozen = 1'b0;
      bit seen = 1'b0;
      while (n < 400 && !seen) begin
         if (!frozen && b_h == 10'd5 && b_v == 10'd2) begin
            en_b = 1'b0;
            frozen = 1'b1;
            repeat (37) begin
               tick();
               n++;
               vec_cnt++;
               if (b_h !== 10'd5 || b_v !== 10'd2 || b_act !== 1'b1) begin
                  err_cnt++;
                  $display("FAIL stretch_hold: got (%0d,%0d) act=%b want (5,2) 1", b_h, b_v, b_act);
               end
            end
            en_b = 1'b1;
         end
         tick();
         n++;
         if (b_fs) seen = 1'b1;
      end
      vec_cnt++;
      if (!seen || n != 197 || b_frame !== 8'h01) begin
         err_cnt++;
         $display("FAIL frame_stretch: got seen=%0d period=%0d frame=%h want 1 197 01", seen, n, b_frame);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_enable_freeze();
      test_async_reset();
      test_small_frame();
      test_frame_wrap();
      test_stretch();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
